// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned PROD_W         = 64;
    localparam int unsigned DEF_LAUNCH_TMO = 8;
    localparam int unsigned DEF_RUN_TMO    = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin grant; search starts one past the pointer.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] p,
                                                  input int unsigned     off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            if (!grant_any && req[cand_idx(ptr, off)]) begin
                grant_any                 = 1'b1;
                grant_idx                 = cand_idx(ptr, off);
                grant[cand_idx(ptr, off)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one start/ready multiplier among NREQ requesters,
// with launch and run watchdogs that turn a silent multiplier into an error response.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned LAUNCH_TMO = DEF_LAUNCH_TMO,
    parameter int unsigned RUN_TMO    = DEF_RUN_TMO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [PROD_W-1:0]      rsp_p,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [DATA_W-1:0]      mul_a,
    output logic [DATA_W-1:0]      mul_b,
    input  logic                   mul_ready,
    input  logic [PROD_W-1:0]      mul_p
);

    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned LCNT_W = $clog2(LAUNCH_TMO + 1);
    localparam int unsigned RCNT_W = $clog2(RUN_TMO + 1);

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [LCNT_W-1:0]   launch_cnt;
    logic [RCNT_W-1:0]   run_cnt;
    logic                mul_ready_q;

    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                launch_seen;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grant is offered only while idle and never during reset.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    // A 1->0 edge, so a multiplier still busy from before is not taken as our launch.
    assign launch_seen = mul_ready_q && !mul_ready;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(NREQ - 1);
            owner       <= '0;
            launch_cnt  <= '0;
            run_cnt     <= '0;
            mul_ready_q <= 1'b0;
            rsp_valid   <= '0;
            rsp_p       <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            mul_ready_q <= mul_ready;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_a      <= sel_a;
                        mul_b      <= sel_b;
                        owner      <= grant_idx;
                        launch_cnt <= '0;
                        mul_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (launch_seen) begin
                        mul_start <= 1'b0;
                        run_cnt   <= '0;
                        state     <= RUN;
                    end else if (launch_cnt == LCNT_W'(LAUNCH_TMO - 1)) begin
                        mul_start <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_p     <= '0;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        launch_cnt <= launch_cnt + LCNT_W'(1);
                    end
                end
                RUN: begin
                    if (mul_ready) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_p     <= mul_p;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end else if (run_cnt == RCNT_W'(RUN_TMO - 1)) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_p     <= '0;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        run_cnt <= run_cnt + RCNT_W'(1);
                    end
                end
                DONE: begin
                    rsp_valid <= '0;
                    rsp_p     <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    rr_ptr    <= owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a start/ready multiplier model.
module tb_mult_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int LAT_OK   = 10;
    localparam int LAT_LTMO = 9;
    localparam int LAT_RTMO = 52;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_p;
    logic                rsp_err;
    logic                busy;
    logic                mul_start;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic                mul_ready;
    logic [63:0]         mul_p;

    always #5 clock = ~clock;

    mult_arbiter #(
        .NREQ       (NREQ),
        .LAUNCH_TMO (8),
        .RUN_TMO    (48)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_p     (mul_p)
    );

    // Multiplier model: mode 0 normal, 1 ignores start (ready stuck 1), 2 never finishes.
    int          mode;
    int          m_phase;
    int          m_cnt;
    logic        m_ready;
    logic [63:0] m_p;
    logic [31:0] m_a, m_b;

    assign mul_ready = m_ready;
    assign mul_p     = m_p;

    always @(posedge clock) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_p     <= '0;
            m_phase <= 0;
            m_cnt   <= 0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            case (m_phase)
                0: if (mode != 1 && mul_start && m_ready) m_phase <= 1;
                1: begin
                    m_ready <= 1'b0;
                    m_a     <= mul_a;
                    m_b     <= mul_b;
                    m_cnt   <= 0;
                    m_phase <= 2;
                end
                default: if (mode != 2) begin
                    if (m_cnt == 5) begin
                        m_ready <= 1'b1;
                        m_p     <= {32'b0, m_a} * {32'b0, m_b};
                        m_phase <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    typedef struct { int idx; logic [31:0] a; logic [31:0] b; } grant_t;
    typedef struct { int idx; logic [63:0] p; logic err; int lat; } rsp_t;

    grant_t exp_g[$];
    rsp_t   exp_r[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    int     grant_cnt = 0;
    int     grant_cyc = 0;
    logic   in_flight = 1'b0;
    logic [31:0] cur_a, cur_b;
    grant_t mon_g;
    rsp_t   mon_r;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: grants and responses are popped against the scoreboard as they appear.
    always @(negedge clock) begin
        if (reset) begin
            in_flight = 1'b0;
        end else begin
            if (req_ready != '0) begin
                if (exp_g.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_grant: got req_ready=%b expected none", req_ready);
                end else begin
                    mon_g = exp_g.pop_front();
                    chk("grant", 64'(req_ready), 64'd1 << mon_g.idx);
                    cur_a     = mon_g.a;
                    cur_b     = mon_g.b;
                    in_flight = 1'b1;
                    grant_cyc = cyc;
                end
                grant_cnt++;
            end else if (in_flight) begin
                chk("mul_a_stable", 64'(mul_a), 64'(cur_a));
                chk("mul_b_stable", 64'(mul_b), 64'(cur_b));
            end
            if (rsp_valid != '0) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << mon_r.idx);
                    chk("rsp_p", rsp_p, mon_r.p);
                    chk("rsp_err", 64'(rsp_err), 64'(mon_r.err));
                    chk("latency", 64'(cyc - grant_cyc), 64'(mon_r.lat));
                    chk("ready_rsp_overlap", 64'(req_ready & rsp_valid), 64'd0);
                    chk("busy_at_rsp", 64'(busy), 64'd1);
                end
                in_flight = 1'b0;
            end
        end
    end

    task automatic put(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic expect_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] p, input logic err, input int lat);
        grant_t g;
        rsp_t   r;
        g = '{idx, a, b};
        r = '{idx, p, err, lat};
        exp_g.push_back(g);
        exp_r.push_back(r);
    endtask

    // Returns #1 after the edge that transfers the k-th new grant.
    task automatic wait_grants(input int k, input int budget);
        int base;
        int n;
        base = grant_cnt;
        n    = 0;
        do begin
            @(posedge clock);
            n++;
        end while (grant_cnt < base + k && n < budget);
        chk("grant_timeout", 64'(grant_cnt >= base + k), 64'd1);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_r.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("rsp_timeout", 64'(exp_r.size()), 64'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_p"},     rsp_p,          64'd0);
        chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag, "_mul_a"},     64'(mul_a),     64'd0);
        chk({tag, "_mul_b"},     64'(mul_b),     64'd0);
    endtask

    initial begin
        mode      = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // All four requesters pending through reset: req_ready must stay low.
        put(0, 32'd3, 32'd5);
        put(1, 32'h0001_0000, 32'h0001_0000);
        put(2, 32'hDEAD_BEEF, 32'd1);
        put(3, 32'h8000_0000, 32'd4);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");

        expect_txn(0, 32'd3, 32'd5, 64'd15, 1'b0, LAT_OK);
        expect_txn(1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, LAT_OK);
        expect_txn(2, 32'hDEAD_BEEF, 32'd1, 64'h0000_0000_DEAD_BEEF, 1'b0, LAT_OK);
        expect_txn(3, 32'h8000_0000, 32'd4, 64'h0000_0002_0000_0000, 1'b0, LAT_OK);
        expect_txn(0, 32'd3, 32'd5, 64'd15, 1'b0, LAT_OK);
        @(posedge clock);
        #1 reset = 1'b0;
        wait_grants(5, 200);
        req_valid = '0;
        wait_drain(200);

        // Single request with a carry into the upper word.
        expect_txn(1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0, LAT_OK);
        put(1, 32'hFFFF_FFFF, 32'd2);
        wait_grants(1, 50);
        req_valid = '0;
        wait_drain(100);

        // Operands scrambled right after accept must not reach the multiplier.
        expect_txn(2, 32'h1234_5678, 32'd9, 64'h0000_0000_A3D7_0A38, 1'b0, LAT_OK);
        put(2, 32'h1234_5678, 32'd9);
        wait_grants(1, 50);
        req_valid = '0;
        req_a[64 +: 32] = 32'hFFFF_FFFF;
        req_b[64 +: 32] = 32'hFFFF_FFFF;
        wait_drain(100);

        expect_txn(3, 32'd0, 32'd0, 64'd0, 1'b0, LAT_OK);
        put(3, 32'd0, 32'd0);
        wait_grants(1, 50);
        req_valid = '0;
        wait_drain(100);

        expect_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, LAT_OK);
        put(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_grants(1, 50);
        req_valid = '0;
        wait_drain(100);

        // Multiplier never drops ready: launch watchdog, then the next requester is served.
        mode = 1;
        expect_txn(1, 32'd11, 32'd22, 64'd0, 1'b1, LAT_LTMO);
        expect_txn(2, 32'd33, 32'd44, 64'd0, 1'b1, LAT_LTMO);
        put(1, 32'd11, 32'd22);
        put(2, 32'd33, 32'd44);
        wait_grants(2, 100);
        req_valid = '0;
        wait_drain(100);

        // Multiplier starts but never finishes: run watchdog.
        mode = 2;
        expect_txn(3, 32'd7, 32'd7, 64'd0, 1'b1, LAT_RTMO);
        put(3, 32'd7, 32'd7);
        wait_grants(1, 50);
        req_valid = '0;
        wait_drain(200);
        mode = 0;
        repeat (10) @(posedge clock);
        #1;

        // Reset during RUN aborts silently; pointer restarts at requester 0.
        begin
            grant_t g;
            g = '{2, 32'd5, 32'd6};
            exp_g.push_back(g);
        end
        put(2, 32'd5, 32'd6);
        wait_grants(1, 50);
        req_valid = '0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        put(0, 32'd6, 32'd7);
        put(2, 32'd8, 32'd9);
        put(3, 32'd10, 32'd11);
        @(posedge clock);
        @(negedge clock);
        check_zero("midrun_reset");
        expect_txn(0, 32'd6, 32'd7, 64'd42, 1'b0, LAT_OK);
        @(posedge clock);
        #1 reset = 1'b0;
        wait_grants(1, 50);
        req_valid = '0;
        wait_drain(100);

        chk("busy_end", 64'(busy), 64'd0);
        chk("grants_left", 64'(exp_g.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
